// File: rtl/req_ack_source_fifo_pkg.sv
// Shared constants and types for the req/ack source FIFO.
// Used by the RTL and by the bench requester/consumer models.
package req_ack_source_fifo_pkg;

  localparam int ACK_SPACING = 2;
  localparam int COUNT_WIDTH = 32;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } serve_state_t;

  function automatic logic [COUNT_WIDTH-1:0] count_inc(
    input logic [COUNT_WIDTH-1:0] c
  );
    return c + 1'b1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Register-array FIFO storage with wrapping pointers.
// One write port and one registered read port.
module sync_fifo_mem #(
  parameter  int data_width = 32,
  parameter  int depth      = 8,
  localparam int addr_width = $clog2(depth)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [data_width-1:0] wr_data,
  input  logic                  rd_en,
  output logic [data_width-1:0] rd_data
);

  logic [data_width-1:0] mem [depth];
  logic [addr_width-1:0] wp;
  logic [addr_width-1:0] rp;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wp] <= wr_data;
  end

  // depth is a power of two, so pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
    end else if (wr_en) begin
      wp <= wp + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rp      <= '0;
      rd_data <= '0;
    end else if (rd_en) begin
      rp      <= rp + 1'b1;
      rd_data <= mem[rp];
    end
  end

endmodule

// File: rtl/req_ack_source_fifo.sv
// Responder end of the req/ack dataflow protocol.
// Host pushes words; a level req is answered with a one-cycle ack.
module req_ack_source_fifo
  import req_ack_source_fifo_pkg::*;
#(
  parameter  int data_width = 32,
  parameter  int depth      = 8,
  localparam int addr_width = $clog2(depth)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [data_width-1:0]  wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [addr_width:0]    level,
  output logic                   overflow,
  input  logic                   req,
  output logic                   ack,
  output logic [data_width-1:0]  dout,
  output logic [COUNT_WIDTH-1:0] count
);

  serve_state_t state;
  serve_state_t state_nx;
  logic         serve;
  logic         push_ok;

  assign full    = (level == (addr_width+1)'(depth));
  assign empty   = (level == '0);
  assign push_ok = wr_en & ~full;
  assign ack     = (state == ACK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // ACK always returns to IDLE, enforcing the idle gap
  always_comb begin
    state_nx = IDLE;
    serve    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req && !empty) begin
          serve    = 1'b1;
          state_nx = ACK;
        end
      end
      ACK: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= '0;
    end else begin
      unique case ({push_ok, serve})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (serve) begin
      count <= count_inc(count);
    end
  end

  sync_fifo_mem #(
    .data_width(data_width),
    .depth     (depth)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (push_ok),
    .wr_data(wr_data),
    .rd_en  (serve),
    .rd_data(dout)
  );

endmodule

// File: tb/tb_req_ack_source_fifo.sv
// Scoreboard bench for req_ack_source_fifo.
// Requester drops req after seeing ack; monitor checks every ack.
module tb_req_ack_source_fifo;
  import req_ack_source_fifo_pkg::*;

  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int AW = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic full, empty, overflow, ack;
  logic [AW:0] level;
  logic [DW-1:0] dout;
  logic [COUNT_WIDTH-1:0] count;
  logic req;
  logic req_want = 1'b0;
  logic drop = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] q[$];
  bit graph = 1'b0;
  int unsigned gk = 0;
  int cyc = 0;
  int last_ack = -100;

  assign req = req_want & ~drop;

  always #5 clk = ~clk;

  req_ack_source_fifo #(.data_width(DW), .depth(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level),
    .overflow(overflow), .req(req), .ack(ack),
    .dout(dout), .count(count)
  );

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor and requester model
  always @(posedge clk) begin
    logic [DW-1:0] e;
    logic [DW-1:0] r;
    #1;
    cyc++;
    if (rst) begin
      drop = 1'b0;
    end else begin
      if (ack) begin
        check("ack_spacing", 64'(cyc - last_ack >= ACK_SPACING), 64'd1);
        last_ack = cyc;
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_ack: got dout %0h, expected none", dout);
        end else begin
          e = q.pop_front();
          check("dout", 64'(dout), 64'(e));
          if (graph) begin
            r = (dout + 32'd2) + dout + dout;
            check("graph_out", 64'(r), 64'(3 * gk + 2));
            gk++;
          end
        end
      end
      drop = ack;
    end
  end

  task automatic push_word(input logic [DW-1:0] d, input bit acc);
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = d;
    if (acc) q.push_back(d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      wr_en = 1'b0;
    end
  endtask

  task automatic drain(input int max);
    int t = 0;
    while (q.size() != 0 && t < max) begin
      @(posedge clk);
      t++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d left, expected 0", q.size());
    end
    idle(3);
  endtask

  initial begin
    int t;
    int i;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_ack", 64'(ack), 0);
    check("rst_dout", 64'(dout), 0);
    check("rst_count", 64'(count), 0);
    check("rst_level", 64'(level), 0);
    check("rst_full", 64'(full), 0);
    check("rst_empty", 64'(empty), 1);
    check("rst_ovf", 64'(overflow), 0);

    // push 5,6,7 with req high
    req_want = 1'b1;
    push_word(5, 1);
    push_word(6, 1);
    push_word(7, 1);
    idle(1);
    drain(40);
    check("t1_count", 64'(count), 3);
    check("t1_level", 64'(level), 0);
    check("t1_empty", 64'(empty), 1);
    req_want = 1'b0;

    // overfill with req low
    for (int k = 0; k < DEPTH + 1; k++)
      push_word(32'h100 + k, k < DEPTH);
    idle(2);
    check("t2_full", 64'(full), 1);
    check("t2_level", 64'(level), DEPTH);
    check("t2_ovf", 64'(overflow), 1);
    // push while full with pop in same cycle: push dropped
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = 32'hDEAD;
    req_want = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    check("t2_full_pushpop", 64'(level), DEPTH - 1);
    drain(60);
    check("t2_ovf_sticky", 64'(overflow), 1);
    check("t2_empty", 64'(empty), 1);

    // req on empty FIFO, then one push
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #2;
      check("t3_idle_ack", 64'(ack), 0);
    end
    push_word(32'h77, 1);
    @(posedge clk);
    #2;
    wr_en = 1'b0;
    check("t3_ack_n", 64'(ack), 0);
    check("t3_level_n", 64'(level), 1);
    @(posedge clk);
    #2;
    check("t3_ack_n1", 64'(ack), 1);
    check("t3_dout_n1", 64'(dout), 32'h77);
    req_want = 1'b0;
    idle(3);

    // level 4 with simultaneous push and pop
    for (int k = 0; k < 4; k++) push_word(32'h200 + k, 1);
    idle(2);
    check("t4_level4", 64'(level), 4);
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = 32'h300;
    q.push_back(32'h300);
    req_want = 1'b1;
    @(posedge clk);
    #2;
    check("t4_level_same", 64'(level), 4);
    check("t4_ack", 64'(ack), 1);
    for (int k = 1; k < 100; k++) begin
      @(negedge clk);
      wr_en = (q.size() < DEPTH - 1) && ($urandom_range(1) == 1);
      wr_data = 32'h300 + k;
      if (wr_en) q.push_back(wr_data);
    end
    idle(1);
    drain(60);
    check("t4_level_end", 64'(level), 0);
    req_want = 1'b0;

    // async reset while ack high
    for (int k = 0; k < 3; k++) push_word(32'h400 + k, 1);
    idle(1);
    req_want = 1'b1;
    t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (!ack && t < 20);
    check("t5_saw_ack", 64'(ack), 1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_ack", 64'(ack), 0);
    check("t5_dout", 64'(dout), 0);
    check("t5_count", 64'(count), 0);
    check("t5_level", 64'(level), 0);
    check("t5_empty", 64'(empty), 1);
    q.delete();
    req_want = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    req_want = 1'b1;
    push_word(32'hAB, 1);
    idle(1);
    drain(20);
    check("t5_count_after", 64'(count), 1);

    // arf graph (x+2)+x+x over 5000 words
    graph = 1'b1;
    i = 0;
    t = 0;
    while (i < 5000 && t < 40000) begin
      @(negedge clk);
      t++;
      if (q.size() < DEPTH - 1) begin
        wr_en = 1'b1;
        wr_data = i;
        q.push_back(i);
        i++;
      end else begin
        wr_en = 1'b0;
      end
    end
    idle(1);
    check("t6_all_pushed", 64'(i), 5000);
    drain(200);
    check("t6_consumed", 64'(gk), 5000);
    check("t6_count", 64'(count), 5001);
    check("t6_empty", 64'(empty), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
